// File: rtl/icache_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// icache_flush_ctrl_if
// Bundles the flush, fetch and tag/valid SRAM handshakes of icache_flush_ctrl.
//   slave  : the flush controller (receives flush/fetch requests, drives SRAM)
//   master : the surrounding logic (fence.i/kill, fetch unit, SRAM model)
// Optional macro ICACHE_FLUSH_PERF_EN adds flush_count_o / flush_cycles_o.
// ---------------------------------------------------------------------------
interface icache_flush_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 4
);
    // flush control
    logic                  flush_req_i;
    logic                  flush_busy_o;
    logic                  flush_done_o;
    // fetch path
    logic                  fetch_req_i;
    logic [ADDR_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_busy_i;
    // tag/valid SRAM port
    logic                  sram_req_o;
    logic                  sram_we_o;
    logic [ADDR_WIDTH-1:0] sram_addr_o;
    logic [WAYS-1:0]       sram_way_mask_o;
    logic                  sram_gnt_i;
`ifdef ICACHE_FLUSH_PERF_EN
    // performance counters
    logic [15:0]           flush_count_o;
    logic [31:0]           flush_cycles_o;

    modport slave (
        input  flush_req_i, fetch_req_i, fetch_addr_i, fetch_busy_i, sram_gnt_i,
        output flush_busy_o, flush_done_o, fetch_gnt_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_way_mask_o,
        output flush_count_o, flush_cycles_o
    );

    modport master (
        output flush_req_i, fetch_req_i, fetch_addr_i, fetch_busy_i, sram_gnt_i,
        input  flush_busy_o, flush_done_o, fetch_gnt_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_way_mask_o,
        input  flush_count_o, flush_cycles_o
    );
`else
    modport slave (
        input  flush_req_i, fetch_req_i, fetch_addr_i, fetch_busy_i, sram_gnt_i,
        output flush_busy_o, flush_done_o, fetch_gnt_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_way_mask_o
    );

    modport master (
        output flush_req_i, fetch_req_i, fetch_addr_i, fetch_busy_i, sram_gnt_i,
        input  flush_busy_o, flush_done_o, fetch_gnt_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_way_mask_o
    );
`endif
endinterface

// File: rtl/icache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// icache_flush_ctrl
// Sequences a full instruction-cache invalidation and shares the tag/valid
// SRAM port between the fetch path and the invalidation sweep.
//   clk_i  : clock, all state on the rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : icache_flush_ctrl_if.slave
//            flush_req_i / flush_busy_o / flush_done_o   flush control
//            fetch_req_i / fetch_addr_i / fetch_gnt_o /
//            fetch_busy_i                                 fetch path
//            sram_req_o / sram_we_o / sram_addr_o /
//            sram_way_mask_o / sram_gnt_i                 tag/valid SRAM port
// Optional macro ICACHE_FLUSH_PERF_EN adds flush_count_o (saturating count of
// completed sweeps) and flush_cycles_o (wrapping count of busy cycles).
// ---------------------------------------------------------------------------
module icache_flush_ctrl #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    icache_flush_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_nxt_s;
    logic                  pending_r;
    logic                  pending_nxt_s;
    logic                  busy_r;
    logic                  done_r;

    logic                  sram_req_s;
    logic                  sram_we_s;
    logic [ADDR_WIDTH-1:0] sram_addr_s;
    logic [WAYS-1:0]       sram_way_mask_s;
    logic                  fetch_gnt_s;

    // State register plus registered status outputs derived from next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_IDX;
            pending_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pending_r <= pending_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Next-state, sweep counter and pending-flush logic
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pending_nxt_s = pending_r;
        case (state_r)
            ST_IDLE: begin
                // A request here starts the sequence directly; it is not pending.
                if (bus.flush_req_i) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.flush_req_i) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                if (!bus.fetch_busy_i) begin
                    state_nxt_s = ST_SWEEP;
                    cnt_nxt_s   = ZERO_IDX;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_SWEEP: begin
                if (bus.flush_req_i) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                // Address advances only on an accepted write; wraps to zero.
                if (bus.sram_gnt_i) begin
                    cnt_nxt_s = cnt_r + ONE_IDX;
                    if (cnt_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SWEEP;
                    end
                end else begin
                    state_nxt_s = ST_SWEEP;
                end
            end
            ST_DONE: begin
                // A request seen in this last cycle is honoured immediately,
                // so it is never left stranded in pending while idle.
                if (pending_r || bus.flush_req_i) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                pending_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = ZERO_IDX;
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    // SRAM port mux and fetch grant
    always_comb begin
        sram_req_s      = 1'b0;
        sram_we_s       = 1'b0;
        sram_addr_s     = ZERO_IDX;
        sram_way_mask_s = '0;
        fetch_gnt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Flush wins a same-cycle collision: no lookup is issued.
                sram_req_s  = bus.fetch_req_i & ~bus.flush_req_i;
                sram_addr_s = bus.fetch_addr_i;
                fetch_gnt_s = bus.fetch_req_i & bus.sram_gnt_i & ~bus.flush_req_i;
            end
            ST_SWEEP: begin
                sram_req_s      = 1'b1;
                sram_we_s       = 1'b1;
                sram_addr_s     = cnt_r;
                sram_way_mask_s = '1;
            end
            ST_DRAIN: begin
                sram_req_s = 1'b0;
            end
            ST_DONE: begin
                sram_req_s = 1'b0;
            end
            default: begin
                sram_req_s = 1'b0;
            end
        endcase
    end

    assign bus.sram_req_o      = sram_req_s;
    assign bus.sram_we_o       = sram_we_s;
    assign bus.sram_addr_o     = sram_addr_s;
    assign bus.sram_way_mask_o = sram_way_mask_s;
    assign bus.fetch_gnt_o     = fetch_gnt_s;
    assign bus.flush_busy_o    = busy_r;
    assign bus.flush_done_o    = done_r;

`ifdef ICACHE_FLUSH_PERF_EN
    logic [15:0] flush_count_r;
    logic [31:0] flush_cycles_r;

    // Saturating sweep counter and wrapping busy-cycle counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_count_r  <= 16'd0;
            flush_cycles_r <= 32'd0;
        end else begin
            if (done_r && (flush_count_r != 16'hFFFF)) begin
                flush_count_r <= flush_count_r + 16'd1;
            end else begin
                flush_count_r <= flush_count_r;
            end
            if (busy_r) begin
                flush_cycles_r <= flush_cycles_r + 32'd1;
            end else begin
                flush_cycles_r <= flush_cycles_r;
            end
        end
    end

    assign bus.flush_count_o  = flush_count_r;
    assign bus.flush_cycles_o = flush_cycles_r;
`endif

endmodule

// File: tb/tb_icache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_flush_ctrl
// Directed scenarios (basic sweep, drain, backpressure, collision, pending,
// reset mid-sweep) followed by randomized traffic, all checked every cycle
// against a reference model that tracks the sweep as a single position:
// -2 idle, -1 draining, 0..DEPTH-1 set being invalidated, DEPTH done cycle.
// ---------------------------------------------------------------------------
module tb_icache_flush_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int WAYS  = 4;

    logic clk_i;
    logic rst_i;

    icache_flush_ctrl_if #(.ADDR_WIDTH(AW), .WAYS(WAYS)) bus ();

    icache_flush_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAYS(WAYS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          m_pos  = -2;
    bit          m_pend = 1'b0;
    int          m_sweeps = 0;
    int          m_cnt  = 0;
    int          m_cyc  = 0;

    // observations of the DUT
    int cyc          = 0;
    int obs_we       = 0;
    int obs_done     = 0;
    int first_done   = -1;
    int first_we     = -1;
    int first_we_adr = -1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pos  = -2;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_cyc  = 0;
    endtask

    // One clock cycle: apply inputs, check at negedge, advance model at posedge.
    task automatic tick(input bit fr, input bit fq, input logic [AW-1:0] fa,
                        input bit fb, input bit sg);
        bit idle;
        bit sweeping;
        bus.flush_req_i  = fr;
        bus.fetch_req_i  = fq;
        bus.fetch_addr_i = fa;
        bus.fetch_busy_i = fb;
        bus.sram_gnt_i   = sg;
        @(negedge clk_i);
        idle     = (m_pos == -2);
        sweeping = (m_pos >= 0) && (m_pos < DEPTH);
        check_val("busy",      32'(bus.flush_busy_o),    32'(!idle));
        check_val("done",      32'(bus.flush_done_o),    32'(m_pos == DEPTH));
        check_val("fetch_gnt", 32'(bus.fetch_gnt_o),     32'(idle && fq && sg && !fr));
        check_val("sram_req",  32'(bus.sram_req_o),      32'(idle ? (fq && !fr) : sweeping));
        check_val("sram_we",   32'(bus.sram_we_o),       32'(sweeping));
        check_val("way_mask",  32'(bus.sram_way_mask_o), sweeping ? 32'hF : 32'h0);
        if (idle && fq && !fr) check_val("fetch_addr", 32'(bus.sram_addr_o), 32'(fa));
        if (sweeping)          check_val("sweep_addr", 32'(bus.sram_addr_o), 32'(m_pos));
`ifdef ICACHE_FLUSH_PERF_EN
        check_val("perf_count",  32'(bus.flush_count_o), 32'(m_cnt));
        check_val("perf_cycles", bus.flush_cycles_o,     32'(m_cyc));
`endif
        if (bus.sram_we_o === 1'b1) begin
            obs_we++;
            if (first_we < 0) begin
                first_we     = cyc;
                first_we_adr = int'(bus.sram_addr_o);
            end
        end
        if (bus.flush_done_o === 1'b1) begin
            obs_done++;
            if (first_done < 0) first_done = cyc;
        end
        @(posedge clk_i);
        if (m_pos == DEPTH) m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        if (m_pos != -2)    m_cyc++;
        if (m_pos == -2) begin
            if (fr) m_pos = -1;
        end else if (m_pos == -1) begin
            if (fr) m_pend = 1'b1;
            if (!fb) m_pos = 0;
        end else if (m_pos < DEPTH) begin
            if (fr) m_pend = 1'b1;
            if (sg) m_pos++;
        end else begin
            m_sweeps++;
            if (m_pend || fr) begin
                m_pend = 1'b0;
                m_pos  = -1;
            end else begin
                m_pos = -2;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_obs();
        obs_we     = 0;
        obs_done   = 0;
        first_done = -1;
        first_we   = -1;
        first_we_adr = -1;
        cyc        = 0;
    endtask

    // Run with fetch quiet until the model is idle; mode 1 toggles the grant.
    task automatic run_to_idle(input bit toggle_gnt);
        int k;
        bit g;
        k = 0;
        g = 1'b1;
        while (m_pos != -2 && k < 5000) begin
            tick(1'b0, 1'b0, '0, 1'b0, toggle_gnt ? g : 1'b1);
            if (m_pos >= 0 && m_pos < DEPTH) g = ~g;
            k++;
        end
        if (k >= 5000) check_val("idle_timeout", 32'(k), 32'd0);
    endtask

    initial begin
        int base;
        rst_i = 1'b1;
        bus.flush_req_i  = 1'b0;
        bus.fetch_req_i  = 1'b0;
        bus.fetch_addr_i = '0;
        bus.fetch_busy_i = 1'b0;
        bus.sram_gnt_i   = 1'b0;
        #2;
        // reset state
        check_val("rst_busy", 32'(bus.flush_busy_o), 32'd0);
        check_val("rst_done", 32'(bus.flush_done_o), 32'd0);
        check_val("rst_gnt",  32'(bus.fetch_gnt_o),  32'd0);
        check_val("rst_req",  32'(bus.sram_req_o),   32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();

        // basic sweep, flush pulse at cycle 0
        clear_obs();
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        run_to_idle(1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_val("basic_done_cycle", 32'(first_done), 32'(DEPTH + 2));
        check_val("basic_first_we",   32'(first_we),   32'd2);
        check_val("basic_writes",     32'(obs_we),     32'(DEPTH));
        check_val("basic_done_cnt",   32'(obs_done),   32'd1);

        // drain: granted fetch at 0, flush at 1, fetch busy through cycle 5
        clear_obs();
        tick(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 2; i <= 5; i++) tick(1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
        run_to_idle(1'b0);
        check_val("drain_first_we",  32'(first_we),     32'd7);
        check_val("drain_first_adr", 32'(first_we_adr), 32'd0);

        // backpressure: grant toggles during the sweep
        clear_obs();
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        run_to_idle(1'b1);
        check_val("bp_sweep_cycles", 32'(obs_we),   32'(2 * DEPTH));
        check_val("bp_done_cnt",     32'(obs_done), 32'd1);

        // collision: fetch and flush in the same idle cycle
        clear_obs();
        tick(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
        check_val("coll_busy_next", 32'(bus.flush_busy_o), 32'd1);
        run_to_idle(1'b0);

        // pending: flush raised while invalidating set 100
        clear_obs();
        base = m_sweeps;
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 1000 && m_pos != 100; k++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        run_to_idle(1'b0);
        check_val("pend_done_cnt", 32'(obs_done),        32'd2);
        check_val("pend_writes",   32'(obs_we),          32'(2 * DEPTH));
        check_val("pend_sweeps",   32'(m_sweeps - base), 32'd2);

        // reset while invalidating set 37
        clear_obs();
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 1000 && m_pos != 37; k++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        rst_i = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(bus.flush_busy_o), 32'd0);
        check_val("mid_rst_we",   32'(bus.sram_we_o),    32'd0);
        check_val("mid_rst_done", 32'(bus.flush_done_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        clear_obs();
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        run_to_idle(1'b0);
        check_val("rst_restart_adr", 32'(first_we_adr), 32'd0);
        check_val("rst_restart_cnt", 32'(obs_done),     32'd1);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            tick(($urandom_range(0, 47) == 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end
        run_to_idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_flush_ctrl.md
Name: icache_flush_ctrl

Overview:
- Sequences instruction-cache invalidation and shares the cache tag/valid SRAM port between the fetch path and the invalidation sweep.
- On a flush request it blocks new fetches and waits for the in-flight lookup to drain.
- It then walks every set index 0..DEPTH-1, issuing one invalidate write per set (all ways), and pulses done.
- Sits between the fetch unit and the icache tag/valid arrays; the fence.i/kill logic raises the flush request.

Parameters:
- DEPTH, 256, number of cache sets to invalidate; power of two, >= 2.
- ADDR_WIDTH, 8, set index width; equals log2(DEPTH).
- WAYS, 4, associativity; width of the way write mask.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- flush_req_i  input  1  request full invalidation; level or pulse.
- flush_busy_o  output  1  high in any state other than IDLE.
- flush_done_o  output  1  one-cycle pulse when a sweep completes.
- fetch_req_i  input  1  fetch wants an SRAM lookup.
- fetch_addr_i  input  ADDR_WIDTH  fetch set index.
- fetch_gnt_o  output  1  fetch lookup accepted this cycle.
- fetch_busy_i  input  1  a granted fetch lookup is still outstanding.
- sram_req_o  output  1  SRAM access request.
- sram_we_o  output  1  1 = invalidate write, 0 = read.
- sram_addr_o  output  ADDR_WIDTH  SRAM set index.
- sram_way_mask_o  output  WAYS  way write enables; all ones on invalidate, zero on read.
- sram_gnt_i  input  1  SRAM accepted the request this cycle.

Behaviour:
- States:
  - IDLE: fetch owns the port.
  - DRAIN: no new fetches; waiting for the outstanding lookup.
  - SWEEP: walking the sets.
  - DONE: one cycle.
- Reset, asynchronous and immediate:
  - state = IDLE; sweep counter = 0; pending = 0.
  - All outputs 0, except that sram_* follow the IDLE mux with fetch_req_i.
  - A reset asserted mid-sweep abandons the sweep; no done pulse is produced.
- IDLE:
  - sram_req_o = fetch_req_i; sram_addr_o = fetch_addr_i; sram_we_o = 0; mask = 0.
  - fetch_gnt_o = fetch_req_i & sram_gnt_i & !flush_req_i.
  - If flush_req_i is high in the same cycle as fetch_req_i, the flush wins: no fetch grant and no SRAM request that cycle. The next state is DRAIN.
- DRAIN:
  - fetch_gnt_o = 0; sram_req_o = 0.
  - Go to SWEEP the first cycle fetch_busy_i is sampled 0. This takes a minimum of 1 cycle in DRAIN.
  - Sweep counter is cleared on entry to SWEEP.
- SWEEP:
  - sram_req_o = 1; sram_we_o = 1; mask = all ones; sram_addr_o = counter.
  - The counter increments only on cycles with sram_gnt_i = 1; with sram_gnt_i = 0 the address and request are held.
  - When the counter equals DEPTH-1 and sram_gnt_i = 1, go to DONE. The counter wraps to 0 (ADDR_WIDTH-bit arithmetic).
- DONE:
  - flush_done_o = 1 for exactly this cycle; sram_req_o = 0; fetch_gnt_o = 0.
  - Next state is DRAIN if pending = 1 (pending is then cleared), else IDLE.
- Pending flush:
  - flush_req_i sampled high in DRAIN, SWEEP or DONE sets pending.
  - Multiple such requests collapse into one re-sweep.
  - Rationale: a fence.i during a sweep must see a sweep that starts after it.
  - flush_req_i high in IDLE is not recorded in pending; it causes the IDLE→DRAIN transition directly.
- Latency, no stalls:
  - flush_req_i at cycle 0 → DRAIN at 1 → SWEEP cycles 2..DEPTH+1 (addresses 0..DEPTH-1) → done at DEPTH+2 → IDLE at DEPTH+3.
- flush_busy_o = (state != IDLE), registered from state.

Optional Feature:
- Macro: ICACHE_FLUSH_PERF_EN.
- When defined, adds output flush_count_o [15:0]:
  - Increments on each flush_done_o pulse and saturates at 16'hFFFF.
  - Cleared by reset.
- When defined, adds output flush_cycles_o [31:0]:
  - Increments every cycle flush_busy_o = 1 and wraps.
  - Cleared by reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic sweep (DEPTH=256, sram_gnt_i=1, fetch_busy_i=0): flush_req_i pulse at cycle 0 → sram_we_o=1 with sram_addr_o 0..255 on cycles 2..257, flush_done_o=1 only at cycle 258, flush_busy_o=0 from cycle 259.
- Drain: fetch granted at cycle 0 with fetch_busy_i held until cycle 5, flush_req_i at cycle 1 → no fetch_gnt_o and no SRAM writes until fetch_busy_i drops; first invalidate at addr 0 one cycle after fetch_busy_i is sampled 0.
- Backpressure: sram_gnt_i toggling 1,0,1,0… during sweep → each address held until granted; 512 SWEEP cycles; no address skipped or repeated after grant.
- Collision: fetch_req_i=1 and flush_req_i=1 in the same IDLE cycle → fetch_gnt_o=0 and sram_req_o=0 that cycle, state DRAIN next.
- Pending: flush_req_i at sweep address 100 → flush_done_o pulse, then DRAIN and a second complete 0..255 sweep, two done pulses total (flush_count_o=2 with ICACHE_FLUSH_PERF_EN).
- Reset mid-sweep: rst_i asserted at address 37 → flush_busy_o, sram_we_o and flush_done_o are 0 immediately; the next flush restarts at address 0.
